// File: rtl/match_result_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : match_result_collector_pkg
// Description : Shared constants and result-entry layout for the collector
//               and the two-lane priority solver that feeds it.
// Revision    : 1.0 - initial release
// ============================================================================
package match_result_collector_pkg;

  // Rule identifier width, common to the solver and the collector
  localparam int RULE_ID_W = 14;

  // Default sequence tag width
  localparam int SEQ_W_DEF = 16;

  // Buffered result entry: rule ID (0 on miss), hit flag, sequence tag
  typedef struct packed {
    logic [RULE_ID_W-1:0] rule;
    logic                 hit;
    logic [SEQ_W_DEF-1:0] seq;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Entry width for non-default rule / sequence widths
  function automatic int entry_width(input int rule_w, input int seq_w);
    return rule_w + 1 + seq_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : match_result_collector_if
// Description : Two-lane solver result ingress plus the ready/valid result
//               stream towards the action engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface match_result_collector_if
  import match_result_collector_pkg::*;
#(
  parameter int RULE_ID = RULE_ID_W,
  parameter int SEQ_W   = SEQ_W_DEF
);

  logic [RULE_ID-1:0] rule_id1;
  logic [RULE_ID-1:0] rule_id2;
  logic               data_valid_in1;
  logic               data_valid_in2;
  logic               action_valid_in1;
  logic               action_valid_in2;

  logic               res_valid;
  logic               res_ready;
  logic [RULE_ID-1:0] res_rule_id;
  logic               res_hit;
  logic [SEQ_W-1:0]   res_seq;

  // Solver / consumer side
  modport master (
    output rule_id1, rule_id2, data_valid_in1, data_valid_in2,
           action_valid_in1, action_valid_in2, res_ready,
    input  res_valid, res_rule_id, res_hit, res_seq
  );

  // Collector side
  modport slave (
    input  rule_id1, rule_id2, data_valid_in1, data_valid_in2,
           action_valid_in1, action_valid_in2, res_ready,
    output res_valid, res_rule_id, res_hit, res_seq
  );

endinterface
`default_nettype wire

// File: rtl/match_result_collector_dual_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dual_wr_fifo
// Description : FWFT FIFO with two ordered write ports (port 1 lands first)
//               and a single read port. wr_en2 is only used with wr_en1.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 31
) (
  input  wire logic                     clk,
  input  wire logic                     RSTn,
  input  wire logic                     wr_en1,
  input  wire logic [WIDTH-1:0]         wr_data1,
  input  wire logic                     wr_en2,
  input  wire logic [WIDTH-1:0]         wr_data2,
  input  wire logic                     rd_en,
  output logic      [WIDTH-1:0]         rd_data,
  output logic      [$clog2(DEPTH):0]   occupancy
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w-1:0] c_one   = c_ptr_w'(1);
  localparam logic [c_ptr_w-1:0] c_two   = c_ptr_w'(2);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w:0]   r_occ;
  logic [c_ptr_w-1:0] w_wptr_p1;
  logic [1:0]         w_n_wr;

  assign w_wptr_p1 = r_wptr + c_one;
  assign w_n_wr    = {1'b0, wr_en1} + {1'b0, wr_en2};

  // Storage: port 1 at the write pointer, port 2 right behind it
  always_ff @(posedge clk) begin
    if (wr_en1) r_mem[r_wptr]    <= wr_data1;
    if (wr_en2) r_mem[w_wptr_p1] <= wr_data2;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (wr_en2)      r_wptr <= r_wptr + c_two;
      else if (wr_en1) r_wptr <= w_wptr_p1;
      if (rd_en)       r_rptr <= r_rptr + c_one;
      r_occ <= r_occ + (c_ptr_w+1)'(w_n_wr) - (c_ptr_w+1)'(rd_en);
    end
  end

  // Head is forced to zero while empty so stale storage never shows
  assign rd_data   = (r_occ != '0) ? r_mem[r_rptr] : '0;
  assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: rtl/match_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : match_result_collector
// Description : Tags two-lane solver results with sequence numbers, buffers
//               them and serialises them onto one ready/valid stream. Counts
//               overflow drops and flags almost-full for ingress throttling.
// Revision    : 1.0 - initial release
// ============================================================================
module match_result_collector
  import match_result_collector_pkg::*;
#(
  parameter int RULE_ID  = RULE_ID_W,
  parameter int DEPTH    = 16,
  parameter int SEQ_W    = 16,
  parameter int AFULL_TH = 4,
  parameter int DROP_W   = 16
) (
  input  wire logic                 clk,
  input  wire logic                 RSTn,
  match_result_collector_if.slave   bus,
  output logic                      almost_full,
  output logic      [DROP_W-1:0]    drop_cnt,
  input  wire logic                 clr_drop
);

  localparam int               c_ptr_w = $clog2(DEPTH);
  localparam int               c_ent_w = entry_width(RULE_ID, SEQ_W);
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w+1)'(DEPTH);
  localparam logic [c_ptr_w:0] c_two   = (c_ptr_w+1)'(2);
  localparam logic [c_ptr_w:0] c_afull = (c_ptr_w+1)'(AFULL_TH);

  typedef struct packed {
    logic [RULE_ID-1:0] rule;
    logic               hit;
    logic [SEQ_W-1:0]   seq;
  } ent_t;

  logic [SEQ_W-1:0]  r_seq;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              r_almost_full;

  ent_t              w_ent1, w_ent2, w_wr_d1, w_wr_d2, w_rd;
  logic              w_wr1, w_wr2, w_pop;
  logic [c_ptr_w:0]  w_occ, w_free, w_occ_next;
  logic [1:0]        w_n_valid, w_n_wr, w_n_drop;
  logic [DROP_W:0]   w_drop_sum;

  assign w_free     = c_depth - w_occ;
  assign w_n_valid  = {1'b0, bus.data_valid_in1} + {1'b0, bus.data_valid_in2};
  assign w_n_wr     = {1'b0, w_wr1} + {1'b0, w_wr2};
  assign w_n_drop   = w_n_valid - w_n_wr;
  assign w_pop      = bus.res_valid && bus.res_ready;
  assign w_occ_next = w_occ + (c_ptr_w+1)'(w_n_wr) - (c_ptr_w+1)'(w_pop);
  assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_W+1)'(w_n_drop);

  // Build lane entries; lane 2 takes the next tag when lane 1 is also valid
  always_comb begin
    w_ent1.rule = bus.action_valid_in1 ? bus.rule_id1 : '0;
    w_ent1.hit  = bus.action_valid_in1;
    w_ent1.seq  = r_seq;
    w_ent2.rule = bus.action_valid_in2 ? bus.rule_id2 : '0;
    w_ent2.hit  = bus.action_valid_in2;
    w_ent2.seq  = r_seq + SEQ_W'(bus.data_valid_in1);
  end

  // Admission against start-of-cycle free space; a lone lane-2 result is
  // compacted onto write port 1
  always_comb begin
    w_wr1   = 1'b0;
    w_wr2   = 1'b0;
    w_wr_d1 = w_ent1;
    w_wr_d2 = w_ent2;
    if (bus.data_valid_in1) begin
      w_wr1 = (w_free != '0);
      w_wr2 = bus.data_valid_in2 && (w_free >= c_two);
    end else if (bus.data_valid_in2) begin
      w_wr1   = (w_free != '0);
      w_wr_d1 = w_ent2;
    end
  end

  dual_wr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_ent_w)
  ) u_fifo (
    .clk       (clk),
    .RSTn      (RSTn),
    .wr_en1    (w_wr1),
    .wr_data1  (w_wr_d1),
    .wr_en2    (w_wr2),
    .wr_data2  (w_wr_d2),
    .rd_en     (w_pop),
    .rd_data   (w_rd),
    .occupancy (w_occ)
  );

  // Sequence counter, saturating drop counter and almost-full flag
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_seq         <= '0;
      r_drop_cnt    <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_seq <= r_seq + SEQ_W'(w_n_valid);
      if (clr_drop)               r_drop_cnt <= '0;
      else if (w_drop_sum[DROP_W]) r_drop_cnt <= '1;
      else                        r_drop_cnt <= w_drop_sum[DROP_W-1:0];
      r_almost_full <= ((c_depth - w_occ_next) <= c_afull);
    end
  end

  assign bus.res_valid   = (w_occ != '0);
  assign bus.res_rule_id = w_rd.rule;
  assign bus.res_hit     = w_rd.hit;
  assign bus.res_seq     = w_rd.seq;
  assign almost_full     = r_almost_full;
  assign drop_cnt        = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_match_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_match_result_collector
// Description : Self-checking bench. Two collectors (16-bit and 4-bit
//               sequence/drop widths) receive identical stimulus; a queue
//               model predicts every emitted entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_result_collector;

  typedef struct packed {
    logic [13:0] rule;
    logic        hit;
    logic [15:0] seq;
  } exp_t;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        clr_drop = 1'b0;
  logic        af_a, af_b;
  logic [15:0] dc_a;
  logic [3:0]  dc_b;

  int   total = 0;
  int   bad   = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   mocc = 0, mseq = 0, mdrop_a = 0, mdrop_b = 0;
  logic mafull = 1'b0;

  match_result_collector_if #(.RULE_ID(14), .SEQ_W(16)) if_a ();
  match_result_collector_if #(.RULE_ID(14), .SEQ_W(4))  if_b ();

  match_result_collector dut_a (
    .clk(clk), .RSTn(RSTn), .bus(if_a.slave),
    .almost_full(af_a), .drop_cnt(dc_a), .clr_drop(clr_drop)
  );

  match_result_collector #(.SEQ_W(4), .DROP_W(4)) dut_b (
    .clk(clk), .RSTn(RSTn), .bus(if_b.slave),
    .almost_full(af_b), .drop_cnt(dc_b), .clr_drop(clr_drop)
  );

  always #5 clk = ~clk;

  // Scoreboard for collector A: compare head on every accepted pop
  always @(negedge clk) begin
    if (RSTn && if_a.res_valid && if_a.res_ready) begin
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL pop_a_unexpected got rule=%h seq=%0d expected no entry",
                 if_a.res_rule_id, if_a.res_seq);
      end else begin
        ea = q_a.pop_front();
        if ({if_a.res_rule_id, if_a.res_hit, if_a.res_seq} !== {ea.rule, ea.hit, ea.seq}) begin
          bad++;
          $display("FAIL pop_a got rule=%h hit=%b seq=%0d expected rule=%h hit=%b seq=%0d",
                   if_a.res_rule_id, if_a.res_hit, if_a.res_seq, ea.rule, ea.hit, ea.seq);
        end
      end
    end
  end

  // Scoreboard for collector B: 4-bit sequence tag
  always @(negedge clk) begin
    if (RSTn && if_b.res_valid && if_b.res_ready) begin
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL pop_b_unexpected got rule=%h seq=%0d expected no entry",
                 if_b.res_rule_id, if_b.res_seq);
      end else begin
        eb = q_b.pop_front();
        if ({if_b.res_rule_id, if_b.res_hit, if_b.res_seq} !== {eb.rule, eb.hit, eb.seq[3:0]}) begin
          bad++;
          $display("FAIL pop_b got rule=%h hit=%b seq=%0d expected rule=%h hit=%b seq=%0d",
                   if_b.res_rule_id, if_b.res_hit, if_b.res_seq, eb.rule, eb.hit, eb.seq[3:0]);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle on both collectors and advance the reference model.
  // Called just after a rising edge; returns 2 time units after the next one.
  task automatic drive(input logic v1, input logic a1, input logic [13:0] r1,
                       input logic v2, input logic a2, input logic [13:0] r2,
                       input logic rdy, input logic clr);
    int   nv, nacc, free, nd;
    exp_t e1, e2;
    logic pop;
    if_a.data_valid_in1 = v1; if_a.action_valid_in1 = a1; if_a.rule_id1 = r1;
    if_a.data_valid_in2 = v2; if_a.action_valid_in2 = a2; if_a.rule_id2 = r2;
    if_a.res_ready = rdy;
    if_b.data_valid_in1 = v1; if_b.action_valid_in1 = a1; if_b.rule_id1 = r1;
    if_b.data_valid_in2 = v2; if_b.action_valid_in2 = a2; if_b.rule_id2 = r2;
    if_b.res_ready = rdy;
    clr_drop = clr;
    nv   = int'(v1) + int'(v2);
    free = 16 - mocc;
    if (v1 && v2) nacc = (free >= 2) ? 2 : ((free == 1) ? 1 : 0);
    else          nacc = (nv == 1 && free >= 1) ? 1 : 0;
    e1.rule = a1 ? r1 : 14'd0; e1.hit = a1; e1.seq = 16'(mseq);
    e2.rule = a2 ? r2 : 14'd0; e2.hit = a2; e2.seq = 16'(mseq + (v1 ? 1 : 0));
    if (v1) begin
      if (nacc >= 1) begin q_a.push_back(e1); q_b.push_back(e1); end
      if (nacc == 2) begin q_a.push_back(e2); q_b.push_back(e2); end
    end else if (v2 && nacc == 1) begin
      q_a.push_back(e2); q_b.push_back(e2);
    end
    nd = nv - nacc;
    mdrop_a = clr ? 0 : ((mdrop_a + nd > 65535) ? 65535 : mdrop_a + nd);
    mdrop_b = clr ? 0 : ((mdrop_b + nd > 15) ? 15 : mdrop_b + nd);
    pop    = (mocc != 0) && rdy;
    mocc   = mocc + nacc - (pop ? 1 : 0);
    mafull = ((16 - mocc) <= 4);
    mseq   = (mseq + nv) % 65536;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 14'd0, rdy, 1'b0);
  endtask

  task automatic apply_reset();
    RSTn = 1'b0;
    if_a.data_valid_in1 = 0; if_a.data_valid_in2 = 0; if_a.action_valid_in1 = 0;
    if_a.action_valid_in2 = 0; if_a.rule_id1 = 0; if_a.rule_id2 = 0; if_a.res_ready = 0;
    if_b.data_valid_in1 = 0; if_b.data_valid_in2 = 0; if_b.action_valid_in1 = 0;
    if_b.action_valid_in2 = 0; if_b.rule_id1 = 0; if_b.rule_id2 = 0; if_b.res_ready = 0;
    clr_drop = 1'b0;
    q_a.delete(); q_b.delete();
    mocc = 0; mseq = 0; mdrop_a = 0; mdrop_b = 0; mafull = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({if_a.res_valid, if_a.res_rule_id, if_a.res_hit, if_a.res_seq} !== 32'd0) begin
      bad++;
      $display("FAIL reset_head_a got v=%b rule=%h hit=%b seq=%0d expected all zero",
               if_a.res_valid, if_a.res_rule_id, if_a.res_hit, if_a.res_seq);
    end
    total++;
    if ({af_a, dc_a, af_b, dc_b} !== 22'd0) begin
      bad++;
      $display("FAIL reset_flags got af_a=%b dc_a=%0d af_b=%b dc_b=%0d expected 0",
               af_a, dc_a, af_b, dc_b);
    end
    total++;
    if ({if_b.res_valid, if_b.res_seq} !== 5'd0) begin
      bad++;
      $display("FAIL reset_head_b got v=%b seq=%0d expected 0", if_b.res_valid, if_b.res_seq);
    end
  endtask

  task automatic test_single_lane();
    drive(1'b1, 1'b1, 14'h0123, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0);
    total++;
    if ({if_a.res_valid, if_a.res_rule_id, if_a.res_hit, if_a.res_seq} !==
        {1'b1, 14'h0123, 1'b1, 16'd0}) begin
      bad++;
      $display("FAIL single_lane_head got v=%b rule=%h hit=%b seq=%0d expected v=1 rule=0123 hit=1 seq=0",
               if_a.res_valid, if_a.res_rule_id, if_a.res_hit, if_a.res_seq);
    end
    idle(1'b1);
    total++;
    if (if_a.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_lane_empty got v=%b expected 0", if_a.res_valid);
    end
  endtask

  task automatic test_both_lanes();
    apply_reset();
    drive(1'b1, 1'b1, 14'd5, 1'b1, 1'b0, 14'h3FFF, 1'b1, 1'b0);
    total++;
    if ({if_a.res_valid, if_a.res_rule_id, if_a.res_hit, if_a.res_seq} !==
        {1'b1, 14'd5, 1'b1, 16'd0}) begin
      bad++;
      $display("FAIL both_lanes_head got v=%b rule=%h hit=%b seq=%0d expected v=1 rule=5 hit=1 seq=0",
               if_a.res_valid, if_a.res_rule_id, if_a.res_hit, if_a.res_seq);
    end
    idle(1'b1);
    idle(1'b1);
    total++;
    if (if_a.res_valid !== 1'b0 || q_a.size() != 0) begin
      bad++;
      $display("FAIL both_lanes_drain got v=%b left=%0d expected v=0 left=0",
               if_a.res_valid, q_a.size());
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 14'($urandom_range(0, 16383)), 1'b1, 1'($urandom_range(0, 1)),
            14'($urandom_range(0, 16383)), 1'b0, 1'b0);
      total++;
      if (af_a !== mafull || af_b !== mafull) begin
        bad++;
        $display("FAIL bp_almost_full cyc=%0d got a=%b b=%b expected %b", i, af_a, af_b, mafull);
      end
    end
    total++;
    if (dc_a !== 16'd24 || dc_b !== 4'd15) begin
      bad++;
      $display("FAIL bp_drop_cnt got a=%0d b=%0d expected a=24 b=15", dc_a, dc_b);
    end
    for (int i = 0; i < 16; i++) idle(1'b1);
    total++;
    if (if_a.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drained got v=%b expected 0", if_a.res_valid);
    end
    drive(1'b1, 1'b1, 14'h077, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0);
    total++;
    if (if_a.res_seq !== 16'd40 || if_b.res_seq !== 4'd8) begin
      bad++;
      $display("FAIL bp_next_seq got a=%0d b=%0d expected a=40 b=8", if_a.res_seq, if_b.res_seq);
    end
    idle(1'b1);
  endtask

  task automatic test_full_pop();
    idle(1'b0);
    drive(1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++)
      drive(1'b1, 1'b1, 14'(100 + i), 1'b1, 1'b1, 14'(200 + i), 1'b0, 1'b0);
    drive(1'b1, 1'b0, 14'd9, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 14'h0AA, 1'b1, 1'b1, 14'h0BB, 1'b1, 1'b0);
    total++;
    if (dc_a !== 16'd1 || dc_b !== 4'd1) begin
      bad++;
      $display("FAIL full_pop_drop got a=%0d b=%0d expected 1", dc_a, dc_b);
    end
    total++;
    if (af_a !== 1'b1) begin
      bad++;
      $display("FAIL full_pop_afull got %b expected 1", af_a);
    end
    for (int i = 0; i < 14; i++) idle(1'b1);
    total++;
    if (if_a.res_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_pop_one_left got v=%b expected 1", if_a.res_valid);
    end
    idle(1'b1);
    total++;
    if (if_a.res_valid !== 1'b0 || q_a.size() != 0) begin
      bad++;
      $display("FAIL full_pop_drained got v=%b left=%0d expected v=0 left=0",
               if_a.res_valid, q_a.size());
    end
  endtask

  task automatic test_seq_wrap_sat();
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 1'b1, 14'(k), 1'b0, 1'b0, 14'd0, 1'b1, 1'b0);
      if (k == 15) begin
        total++;
        if (if_b.res_seq !== 4'hF) begin
          bad++;
          $display("FAIL wrap_seq15 got %0d expected 15", if_b.res_seq);
        end
      end
      if (k == 16) begin
        total++;
        if (if_b.res_seq !== 4'h0 || if_a.res_seq !== 16'd16) begin
          bad++;
          $display("FAIL wrap_seq0 got b=%0d a=%0d expected b=0 a=16", if_b.res_seq, if_a.res_seq);
        end
      end
    end
    idle(1'b1);
    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b0, 14'd1, 1'b1, 1'b1, 14'd2, 1'b0, 1'b0);
    total++;
    if (dc_b !== 4'hF || dc_a !== 16'd16) begin
      bad++;
      $display("FAIL sat_reach got b=%0d a=%0d expected b=15 a=16", dc_b, dc_a);
    end
    drive(1'b1, 1'b1, 14'd3, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0);
    total++;
    if (dc_b !== 4'hF || dc_a !== 16'd17) begin
      bad++;
      $display("FAIL sat_hold got b=%0d a=%0d expected b=15 a=17", dc_b, dc_a);
    end
    drive(1'b1, 1'b1, 14'd4, 1'b1, 1'b1, 14'd5, 1'b0, 1'b1);
    total++;
    if (dc_b !== 4'd0 || dc_a !== 16'd0) begin
      bad++;
      $display("FAIL clr_priority got b=%0d a=%0d expected 0", dc_b, dc_a);
    end
    for (int i = 0; i < 16; i++) idle(1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b1, 14'(50 + i), 1'b1, 1'b0, 14'd0, 1'b0, 1'b0);
    #1;
    RSTn = 1'b0;
    #1;
    total++;
    if (if_a.res_valid !== 1'b0 || if_b.res_valid !== 1'b0 || af_a !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got va=%b vb=%b af=%b expected 0",
               if_a.res_valid, if_b.res_valid, af_a);
    end
    apply_reset();
    drive(1'b1, 1'b1, 14'h02A, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0);
    total++;
    if ({if_a.res_valid, if_a.res_rule_id, if_a.res_seq} !== {1'b1, 14'h02A, 16'd0}) begin
      bad++;
      $display("FAIL reset_mid_next got v=%b rule=%h seq=%0d expected v=1 rule=02a seq=0",
               if_a.res_valid, if_a.res_rule_id, if_a.res_seq);
    end
    idle(1'b1);
    idle(1'b1);
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_both_lanes();
    test_backpressure();
    test_full_pop();
    test_seq_wrap_sat();
    test_reset_mid();
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got a=%0d b=%0d expected 0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
